text_mem_ctrl: RTL and testbench
================================

Name: text_mem_ctrl

Overview:
- Single-port controller for the 80-column x 48-row, 8-bit character memory.
- Shares the memory port between two requesters: a character-stream writer that is cursor-driven, and a display scan-out reader with fixed priority.
- Interprets control codes: CR, LF, backspace, and form-feed clear-screen.
- Sits between the input path (keyboard/UART decoder) and the memory array; drives its row/column address, write data and write enable.

Parameters:
- COLS, 80, columns per row; column index range is 0..COLS-1.
- ROWS, 48, rows; row index range is 0..ROWS-1.
- DW, 8, character width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- clr_n  in  1  reset; asynchronous, active-low.
- ch_valid  in  1  writer presents a character.
- ch_data  in  DW  character code.
- ch_ready  out  1  controller accepts ch_data this cycle.
- rd_req  in  1  display read request; single-cycle, no ready.
- rd_row  in  6  display read row.
- rd_col  in  7  display read column.
- rd_valid  out  1  read data valid.
- rd_data  out  DW  read data.
- mem_row  out  6  memory row select (line index).
- mem_col  out  7  memory column select.
- mem_wdata  out  DW  memory write data.
- mem_we  out  1  memory write strobe.
- mem_rdata  in  DW  memory read data; combinational from mem_row/mem_col.
- cur_row  out  6  cursor row.
- cur_col  out  7  cursor column.
- busy  out  1  clear sweep in progress.

Behaviour:
- Reset (clr_n=0, asynchronous) drives the following outputs:
  - state=IDLE, cur_row=0, cur_col=0.
  - rd_valid=0, rd_data=0, busy=0.
  - mem_we=0, mem_row=0, mem_col=0, mem_wdata=0.
- Port arbitration (combinational, per cycle):
  - rd_req=1 always wins the port: mem_row=rd_row, mem_col=rd_col, mem_we=0.
  - rd_data is registered from mem_rdata at the edge ending that cycle.
  - rd_valid=1 the following cycle. Read latency is exactly 1; back-to-back reads give a rd_valid pulse every cycle.
  - Out-of-range rd_row/rd_col are not checked; rd_data is whatever the memory returns.
- ch_ready = (state==IDLE) & ~rd_req. A character transfers when ch_valid & ch_ready, and its memory write (if any) happens in that same cycle.
- IDLE character handling:
  - 0x0D: cur_col=0; no write.
  - 0x0A: cur_col=0, row advances; no write.
  - 0x08: if cur_col>0, write 0x20 at (cur_row, cur_col-1) and cur_col decrements. If cur_col==0: no write, no move.
  - 0x0C: no write; go to CLEAR with sweep counter (0,0).
  - Any other code: write ch_data at (cur_row, cur_col), then column advances.
- Column advance: if cur_col==COLS-1, set cur_col=0 and row advances; else cur_col+1.
- Row advance: if cur_row==ROWS-1, cur_row=0 (wrap, no scroll); else cur_row+1.
- CLEAR state:
  - busy=1, ch_ready=0.
  - Each cycle with rd_req=0: write 0x20 at the sweep counter, which advances column-major-within-row (col 0..COLS-1, then next row).
  - A cycle with rd_req=1 stalls the sweep and holds the counter.
  - After writing (ROWS-1, COLS-1): cursor=(0,0) and state returns to IDLE on the next edge. busy falls in that same edge.
  - Total is COLS*ROWS = 3840 write cycles with no read interference.
- Simultaneous events:
  - rd_req together with ch_valid: the read is served, the character is held (ch_ready=0), and the writer must keep ch_valid/ch_data stable.
  - ch_valid during CLEAR is ignored until IDLE.
- Reset mid-CLEAR aborts the sweep: the memory is left partly cleared and state=IDLE.
- The FSM has only IDLE and CLEAR; the next state is always a legal encoding.

Optional Feature:
- Macro: TEXT_MEM_CTRL_BOOTCLR_EN.
- Defined: reset state is CLEAR with sweep counter (0,0), and busy=1 during reset. After clr_n deasserts, a full 3840-cycle sweep runs before the first ch_ready.
- Undefined: reset state is IDLE and memory contents are left untouched.

Test Plan:
- Reset, then write 'A'(0x41), 'B'(0x42) with rd_req=0 -> mem_we pulses at (0,0)=0x41 and (0,1)=0x42; cur=(0,2).
- Cursor at (0,79), write 0x5A -> write at (0,79); cur=(1,0). Cursor at (47,79), write 0x5A -> cur=(0,0).
- Cursor (3,5): send 0x08 -> 0x20 written at (3,4), cur=(3,4). Cursor (3,0): send 0x08 -> no mem_we, cur unchanged. Send 0x0A -> cur=(4,0), no write.
- Hold ch_valid=1 with 0x41 while rd_req=1 for 3 cycles at (10,20) -> ch_ready=0 for those cycles; mem_we=0; rd_valid=1 on each following cycle with rd_data=mem_rdata. The write completes in the first cycle with rd_req=0.
- Send 0x0C -> busy=1. With rd_req asserted every 4th cycle, busy lasts 3840 write cycles plus the number of stall cycles. Every cell ends at 0x20, then cur=(0,0) and ch_ready=1.
- Assert clr_n=0 mid-CLEAR -> immediate IDLE, busy=0, cur=(0,0). With TEXT_MEM_CTRL_BOOTCLR_EN defined, a fresh sweep restarts after release.

Source files
------------

// File: rtl/text_mem_ctrl.sv
// text_mem_ctrl: cursor-driven character writer plus display scan-out reader
// sharing one port of the COLS x ROWS character memory; decodes CR/LF/BS/FF.
// Latency: writes land in the accepting cycle; reads return data 1 cycle later.
// Backpressure: rd_req always wins the port (ch_ready=0); no characters accepted during a clear sweep.
//
// Ports:
//   clk, clr_n                      clock, async active-low reset
//   ch_valid/ch_data/ch_ready       character stream from the input decoder
//   rd_req/rd_row/rd_col            display read request (no ready)
//   rd_valid/rd_data                registered read response
//   mem_row/mem_col/mem_wdata/mem_we/mem_rdata   memory port (rdata combinational)
//   cur_row/cur_col                 current cursor
//   busy                            clear sweep in progress
//
// Optional: define TEXT_MEM_CTRL_BOOTCLR_EN to come out of reset in the clear
// sweep, so the screen is blanked before the first character is accepted.

module text_mem_ctrl #(
    parameter int COLS = 80,
    parameter int ROWS = 48,
    parameter int DW   = 8
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          ch_valid,
    input  logic [DW-1:0] ch_data,
    output logic          ch_ready,
    input  logic          rd_req,
    input  logic [5:0]    rd_row,
    input  logic [6:0]    rd_col,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic [5:0]    mem_row,
    output logic [6:0]    mem_col,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,
    output logic [5:0]    cur_row,
    output logic [6:0]    cur_col,
    output logic          busy
);

    typedef enum logic [0:0] {ST_IDLE, ST_CLEAR} state_t;

`ifdef TEXT_MEM_CTRL_BOOTCLR_EN
    localparam state_t RST_STATE = ST_CLEAR;
`else
    localparam state_t RST_STATE = ST_IDLE;
`endif

    localparam logic [DW-1:0] C_CR    = DW'(8'h0D);
    localparam logic [DW-1:0] C_LF    = DW'(8'h0A);
    localparam logic [DW-1:0] C_BS    = DW'(8'h08);
    localparam logic [DW-1:0] C_FF    = DW'(8'h0C);
    localparam logic [DW-1:0] C_SPACE = DW'(8'h20);
    localparam logic [5:0]    LAST_ROW = 6'(ROWS - 1);
    localparam logic [6:0]    LAST_COL = 7'(COLS - 1);

    state_t        r_state, w_state_nxt;
    logic [5:0]    r_cur_row, w_cur_row_nxt;
    logic [6:0]    r_cur_col, w_cur_col_nxt;
    logic [5:0]    r_sw_row, w_sw_row_nxt;
    logic [6:0]    r_sw_col, w_sw_col_nxt;
    logic          r_rd_valid;
    logic [DW-1:0] r_rd_data;

    // Row advance wraps to the top; there is no scrolling.
    function automatic logic [5:0] f_row_inc(input logic [5:0] row);
        return (row == LAST_ROW) ? 6'd0 : row + 6'd1;
    endfunction

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state    <= RST_STATE;
            r_cur_row  <= '0;
            r_cur_col  <= '0;
            r_sw_row   <= '0;
            r_sw_col   <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cur_row  <= w_cur_row_nxt;
            r_cur_col  <= w_cur_col_nxt;
            r_sw_row   <= w_sw_row_nxt;
            r_sw_col   <= w_sw_col_nxt;
            r_rd_valid <= rd_req;
            if (rd_req)
                r_rd_data <= mem_rdata;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cur_row_nxt = r_cur_row;
        w_cur_col_nxt = r_cur_col;
        w_sw_row_nxt  = r_sw_row;
        w_sw_col_nxt  = r_sw_col;
        mem_row       = '0;
        mem_col       = '0;
        mem_wdata     = '0;
        mem_we        = 1'b0;
        // Port outputs are held idle while reset is asserted, since the
        // requester inputs are not qualified by reset on their own.
        if (clr_n) begin
            if (rd_req) begin
                mem_row = rd_row;
                mem_col = rd_col;
            end else if (r_state == ST_CLEAR) begin
                mem_we    = 1'b1;
                mem_row   = r_sw_row;
                mem_col   = r_sw_col;
                mem_wdata = C_SPACE;
                if (r_sw_col == LAST_COL) begin
                    w_sw_col_nxt = '0;
                    if (r_sw_row == LAST_ROW) begin
                        w_sw_row_nxt  = '0;
                        w_state_nxt   = ST_IDLE;
                        w_cur_row_nxt = '0;
                        w_cur_col_nxt = '0;
                    end else begin
                        w_sw_row_nxt = r_sw_row + 6'd1;
                    end
                end else begin
                    w_sw_col_nxt = r_sw_col + 7'd1;
                end
            end else if (ch_valid) begin
                case (ch_data)
                    C_CR: w_cur_col_nxt = '0;
                    C_LF: begin
                        w_cur_col_nxt = '0;
                        w_cur_row_nxt = f_row_inc(r_cur_row);
                    end
                    C_BS: begin
                        if (r_cur_col != 7'd0) begin
                            mem_we        = 1'b1;
                            mem_row       = r_cur_row;
                            mem_col       = r_cur_col - 7'd1;
                            mem_wdata     = C_SPACE;
                            w_cur_col_nxt = r_cur_col - 7'd1;
                        end
                    end
                    C_FF: begin
                        w_state_nxt  = ST_CLEAR;
                        w_sw_row_nxt = '0;
                        w_sw_col_nxt = '0;
                    end
                    default: begin
                        mem_we    = 1'b1;
                        mem_row   = r_cur_row;
                        mem_col   = r_cur_col;
                        mem_wdata = ch_data;
                        if (r_cur_col == LAST_COL) begin
                            w_cur_col_nxt = '0;
                            w_cur_row_nxt = f_row_inc(r_cur_row);
                        end else begin
                            w_cur_col_nxt = r_cur_col + 7'd1;
                        end
                    end
                endcase
            end
        end
    end

    assign ch_ready = clr_n & (r_state == ST_IDLE) & ~rd_req;
    assign busy     = (r_state == ST_CLEAR);
    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;
    assign cur_row  = r_cur_row;
    assign cur_col  = r_cur_col;

endmodule

// File: tb/tb_text_mem_ctrl.sv
module tb_text_mem_ctrl;
    localparam int COLS  = 80;
    localparam int ROWS  = 48;
    localparam int TOTAL = COLS * ROWS;
`ifdef TEXT_MEM_CTRL_BOOTCLR_EN
    localparam bit BOOTCLR = 1'b1;
`else
    localparam bit BOOTCLR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       clr_n;
    logic       ch_valid;
    logic [7:0] ch_data;
    logic       ch_ready;
    logic       rd_req;
    logic [5:0] rd_row;
    logic [6:0] rd_col;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic [5:0] mem_row;
    logic [6:0] mem_col;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic [7:0] mem_rdata;
    logic [5:0] cur_row;
    logic [6:0] cur_col;
    logic       busy;

    always #5 clk = ~clk;

    text_mem_ctrl #(.COLS(COLS), .ROWS(ROWS), .DW(8)) dut (
        .clk(clk), .clr_n(clr_n), .ch_valid(ch_valid), .ch_data(ch_data),
        .ch_ready(ch_ready), .rd_req(rd_req), .rd_row(rd_row), .rd_col(rd_col),
        .rd_valid(rd_valid), .rd_data(rd_data), .mem_row(mem_row),
        .mem_col(mem_col), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .cur_row(cur_row), .cur_col(cur_col), .busy(busy)
    );

    // Memory array the controller drives (environment, not the reference).
    logic [7:0] tmem [0:63][0:127];
    assign mem_rdata = tmem[mem_row][mem_col];
    always @(posedge clk) if (mem_we) tmem[mem_row][mem_col] <= mem_wdata;

    // Reference model: linear cursor position and expected screen contents.
    int         m_pos;
    bit         m_clear;
    int         m_idx;
    logic [7:0] exp_mem [TOTAL];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_step(input bit vld, input logic [7:0] d, input bit rd,
                              output bit e_rdy, output bit e_busy, output bit e_we,
                              output int e_r, output int e_c, output int e_wd);
        e_busy = m_clear;
        e_rdy  = !rd && !m_clear;
        e_we = 0; e_r = 0; e_c = 0; e_wd = 0;
        if (rd) begin
        end else if (m_clear) begin
            e_we = 1; e_r = m_idx / COLS; e_c = m_idx % COLS; e_wd = 8'h20;
            exp_mem[m_idx] = 8'h20;
            m_idx++;
            if (m_idx == TOTAL) begin m_clear = 0; m_pos = 0; end
        end else if (vld) begin
            case (d)
                8'h0D: m_pos = m_pos - m_pos % COLS;
                8'h0A: m_pos = ((m_pos / COLS + 1) % ROWS) * COLS;
                8'h08: if (m_pos % COLS > 0) begin
                    m_pos--;
                    e_we = 1; e_r = m_pos / COLS; e_c = m_pos % COLS; e_wd = 8'h20;
                    exp_mem[m_pos] = 8'h20;
                end
                8'h0C: begin m_clear = 1; m_idx = 0; end
                default: begin
                    e_we = 1; e_r = m_pos / COLS; e_c = m_pos % COLS; e_wd = d;
                    exp_mem[m_pos] = d;
                    m_pos = (m_pos + 1) % TOTAL;
                end
            endcase
        end
    endtask

    // One clock of stimulus, called at posedge+1; checks against the model.
    task automatic do_cycle(input bit vld, input logic [7:0] d, input bit rd,
                            input int rr, input int rc);
        bit e_rdy, e_busy, e_we;
        int e_r, e_c, e_wd, e_rdd;
        ch_valid = vld; ch_data = d; rd_req = rd;
        rd_row = 6'(rr); rd_col = 7'(rc);
        #3;
        e_rdd = exp_mem[rr * COLS + rc];
        model_step(vld, d, rd, e_rdy, e_busy, e_we, e_r, e_c, e_wd);
        chk("ch_ready", ch_ready, e_rdy);
        chk("busy", busy, e_busy);
        chk("mem_we", mem_we, e_we);
        if (e_we) begin
            chk("wr_row", mem_row, e_r);
            chk("wr_col", mem_col, e_c);
            chk("wr_data", mem_wdata, e_wd);
        end
        if (rd) begin
            chk("rd_port_row", mem_row, rr);
            chk("rd_port_col", mem_col, rc);
        end
        @(posedge clk); #1;
        chk("cur_row", cur_row, m_pos / COLS);
        chk("cur_col", cur_col, m_pos % COLS);
        chk("rd_valid", rd_valid, rd);
        if (rd) chk("rd_data", rd_data, e_rdd);
    endtask

    task automatic send(input logic [7:0] d, input int n);
        for (int i = 0; i < n; i++) do_cycle(1, d, 0, 0, 0);
    endtask

    // Runs a sweep with a read every 4th cycle; checks duration and result.
    task automatic run_clear();
        int cyc = 0, stalls = 0, nonspace = 0;
        for (int k = 0; k < 6000 && busy; k++) begin
            bit rd = (k % 4 == 3);
            if (rd) stalls++;
            do_cycle(0, 8'h00, rd, $urandom_range(0, ROWS - 1), $urandom_range(0, COLS - 1));
            cyc++;
        end
        chk("clear_cycles", cyc, TOTAL + stalls);
        chk("busy_after_clear", busy, 0);
        chk("ready_after_clear", ch_ready, 1);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (tmem[r][c] !== 8'h20) nonspace++;
        chk("cells_not_space", nonspace, 0);
    endtask

    typedef struct {
        bit         vld;
        logic [7:0] d;
        bit         rd;
        int         rr, rc;
        bit         e_rdy, e_we;
        int         e_row, e_col, e_wd;
        bit         e_rdv;
        int         e_cr, e_cc;
    } vec_t;

    initial begin
        vec_t vt [8];
        bit   xr, xb, xw;
        int   xrow, xcol, xwd;

        vt[0] = '{1, 8'h41, 0, 0, 0, 1, 1, 0, 0, 8'h41, 0, 0, 1};
        vt[1] = '{1, 8'h42, 0, 0, 0, 1, 1, 0, 1, 8'h42, 0, 0, 2};
        vt[2] = '{1, 8'h08, 0, 0, 0, 1, 1, 0, 1, 8'h20, 0, 0, 1};
        vt[3] = '{1, 8'h0D, 0, 0, 0, 1, 0, 0, 0, 0,     0, 0, 0};
        vt[4] = '{1, 8'h08, 0, 0, 0, 1, 0, 0, 0, 0,     0, 0, 0};
        vt[5] = '{1, 8'h0A, 0, 0, 0, 1, 0, 0, 0, 0,     0, 1, 0};
        vt[6] = '{1, 8'h43, 1, 2, 3, 0, 0, 2, 3, 0,     1, 1, 0};
        vt[7] = '{1, 8'h43, 0, 0, 0, 1, 1, 1, 0, 8'h43, 0, 1, 1};

        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 128; c++) tmem[r][c] = 8'h00;
        for (int i = 0; i < TOTAL; i++) exp_mem[i] = 8'h00;
        m_pos = 0; m_clear = BOOTCLR; m_idx = 0;

        clr_n = 0; ch_valid = 0; ch_data = 0; rd_req = 0; rd_row = 0; rd_col = 0;
        #12;
        chk("rst_cur_row", cur_row, 0);
        chk("rst_cur_col", cur_col, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_busy", busy, BOOTCLR);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_row", mem_row, 0);
        chk("rst_mem_col", mem_col, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        @(posedge clk); #1;
        clr_n = 1;
        if (BOOTCLR) run_clear();

        // Table-driven basics from a home cursor.
        for (int i = 0; i < 8; i++) begin
            ch_valid = vt[i].vld; ch_data = vt[i].d; rd_req = vt[i].rd;
            rd_row = 6'(vt[i].rr); rd_col = 7'(vt[i].rc);
            #3;
            model_step(vt[i].vld, vt[i].d, vt[i].rd, xr, xb, xw, xrow, xcol, xwd);
            chk("tbl_ready", ch_ready, vt[i].e_rdy);
            chk("tbl_we", mem_we, vt[i].e_we);
            if (vt[i].e_we || vt[i].rd) begin
                chk("tbl_row", mem_row, vt[i].e_row);
                chk("tbl_col", mem_col, vt[i].e_col);
            end
            if (vt[i].e_we) chk("tbl_wdata", mem_wdata, vt[i].e_wd);
            @(posedge clk); #1;
            chk("tbl_rd_valid", rd_valid, vt[i].e_rdv);
            chk("tbl_cur_row", cur_row, vt[i].e_cr);
            chk("tbl_cur_col", cur_col, vt[i].e_cc);
        end

        // Right-edge and bottom-right wrap: cursor now (1,1).
        send(8'h0A, 47);          // (0,0)
        send(8'h78, 79);          // (0,79)
        do_cycle(1, 8'h5A, 0, 0, 0);
        chk("wrap_eol_row", cur_row, 1);
        chk("wrap_eol_col", cur_col, 0);
        send(8'h0A, 46);          // (47,0)
        send(8'h79, 79);          // (47,79)
        do_cycle(1, 8'h5A, 0, 0, 0);
        chk("wrap_eos_row", cur_row, 0);
        chk("wrap_eos_col", cur_col, 0);

        // Character held behind three reads at cursor (10,20).
        send(8'h0A, 10);
        send(8'h61, 20);
        for (int i = 0; i < 3; i++)
            do_cycle(1, 8'h41, 1, $urandom_range(0, ROWS - 1), $urandom_range(0, COLS - 1));
        do_cycle(1, 8'h41, 0, 0, 0);
        chk("held_wr_cell", tmem[10][20], 8'h41);

        // Randomised mix of printables, CR/LF/BS and reads.
        for (int i = 0; i < 400; i++) begin
            int sel = $urandom_range(0, 9);
            logic [7:0] d = (sel == 0) ? 8'h0D : (sel == 1) ? 8'h0A :
                            (sel <= 3) ? 8'h08 : 8'($urandom_range(8'h21, 8'h7E));
            do_cycle($urandom_range(0, 3) != 0, d, $urandom_range(0, 3) == 0,
                     $urandom_range(0, ROWS - 1), $urandom_range(0, COLS - 1));
        end

        // Full clear with periodic read stalls.
        do_cycle(1, 8'h0C, 0, 0, 0);
        chk("ff_busy", busy, 1);
        run_clear();
        chk("clr_cur_row", cur_row, 0);
        chk("clr_cur_col", cur_col, 0);

        // Reset in the middle of a sweep.
        send(8'h51, 5);
        do_cycle(1, 8'h0C, 0, 0, 0);
        for (int i = 0; i < 100; i++) do_cycle(0, 8'h00, 0, 0, 0);
        clr_n = 0;
        #1;
        chk("midrst_busy", busy, BOOTCLR);
        chk("midrst_cur_row", cur_row, 0);
        chk("midrst_cur_col", cur_col, 0);
        chk("midrst_mem_we", mem_we, 0);
        chk("midrst_ready", ch_ready, 0);
        m_pos = 0; m_clear = BOOTCLR; m_idx = 0;
        @(posedge clk); #1;
        clr_n = 1;
        if (BOOTCLR) run_clear();
        do_cycle(1, 8'h4B, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
